wr_ingress_ctrl: RTL and testbench

WR_INGRESS_CTRL -- requirements
Module: wr_ingress_ctrl

---
 rtl/wr_ingress_ctrl.sv | 106 ++++++++++
 tb/tb_wr_ingress_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_ingress_ctrl.sv
// Write-side ingress for an async FIFO: two-entry skid buffer, read-pointer
// synchronizer, occupancy level, almost-full, write counter and integrity flag.
module wr_ingress_ctrl #(
    parameter int WIDTH     = 5,
    parameter int DW        = 8,
    parameter int AF_THRESH = 28
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             full,
    input  logic [WIDTH:0]   waddr,
    input  logic [WIDTH:0]   rptr_gray,
    output logic             wen,
    output logic [DW-1:0]    wdata,
    output logic [WIDTH:0]   rptr_sync,
    output logic [WIDTH:0]   level,
    output logic             almost_full,
    output logic [15:0]      wr_count,
    output logic             level_err
);

    localparam logic [WIDTH:0] AF_LVL = (WIDTH+1)'(AF_THRESH);
    localparam logic [WIDTH:0] DEPTH  = (WIDTH+1)'(1 << WIDTH);

    logic [DW-1:0]  r_mem [2];
    logic           r_hd;
    logic [1:0]     r_cnt;
    logic [WIDTH:0] r_s1;
    logic [WIDTH:0] r_s2;
    logic [WIDTH:0] r_lvl;
    logic           r_af;
    logic [15:0]    r_wcnt;
    logic           r_err;

    logic           w_acc;
    logic           w_drn;
    logic           w_tl;
    logic [WIDTH:0] w_rbin;
    logic [WIDTH:0] w_lvl;

    assign in_ready = (r_cnt != 2'd2);
    assign wen      = (r_cnt != 2'd0);
    assign wdata    = r_mem[r_hd];
    assign w_acc    = in_valid & in_ready;
    assign w_drn    = wen & ~full;
    // tail sits one slot past head only when exactly one word is held
    assign w_tl     = r_hd ^ (r_cnt == 2'd1);

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_hd     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_acc)
                r_mem[w_tl] <= in_data;
            if (w_drn)
                r_hd <= ~r_hd;
            r_cnt <= r_cnt + {1'b0, w_acc} - {1'b0, w_drn};
        end
    end

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= rptr_gray;
            r_s2 <= r_s1;
        end
    end

    assign rptr_sync = r_s2;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_g2b
        assign w_rbin[i] = ^r_s2[WIDTH:i];
    end

    assign w_lvl = waddr - w_rbin;

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            r_lvl  <= '0;
            r_af   <= 1'b0;
            r_wcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_lvl <= w_lvl;
            r_af  <= (r_lvl >= AF_LVL);
            if (w_drn && r_wcnt != 16'hFFFF)
                r_wcnt <= r_wcnt + 16'd1;
            if (w_lvl > DEPTH)
                r_err <= 1'b1;
        end
    end

    assign level       = r_lvl;
    assign almost_full = r_af;
    assign wr_count    = r_wcnt;
    assign level_err   = r_err;

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// Scoreboard bench for wr_ingress_ctrl: data order, handshake, pointer
// synchronizer, level/almost-full/error flags and asynchronous reset.
module tb_wr_ingress_ctrl;

    localparam int WIDTH = 5;
    localparam int DW    = 8;

    logic             wclk = 1'b0;
    logic             wrst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_data = '0;
    logic             full = 1'b0;
    logic [WIDTH:0]   waddr = '0;
    logic [WIDTH:0]   rptr_gray = '0;
    logic             wen;
    logic [DW-1:0]    wdata;
    logic [WIDTH:0]   rptr_sync;
    logic [WIDTH:0]   level;
    logic             almost_full;
    logic [15:0]      wr_count;
    logic             level_err;

    int checks = 0;
    int errors = 0;
    int m_cnt  = 0;
    logic [DW-1:0] sb[$];

    wr_ingress_ctrl #(.WIDTH(WIDTH), .DW(DW), .AF_THRESH(28)) dut (
        .wclk(wclk), .wrst(wrst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .full(full), .waddr(waddr), .rptr_gray(rptr_gray),
        .wen(wen), .wdata(wdata), .rptr_sync(rptr_sync),
        .level(level), .almost_full(almost_full),
        .wr_count(wr_count), .level_err(level_err)
    );

    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    // mid-cycle monitor: model count, scoreboard push on accept, pop on drain
    always @(negedge wclk) begin
        if (wrst) begin
            checks++;
            if (in_ready !== (m_cnt != 2)) begin
                errors++;
                $display("FAIL mon_in_ready: got %b want %b", in_ready, m_cnt != 2);
            end
            checks++;
            if (wen !== (m_cnt != 0)) begin
                errors++;
                $display("FAIL mon_wen: got %b want %b", wen, m_cnt != 0);
            end
            if (wen === 1'b1 && full === 1'b0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got wdata %h want none", wdata);
                end else begin
                    logic [DW-1:0] e;
                    e = sb.pop_front();
                    if (wdata !== e) begin
                        errors++;
                        $display("FAIL sb_wdata: got %h want %h", wdata, e);
                    end
                end
                m_cnt--;
            end
            if (in_valid === 1'b1 && m_cnt < 2 + ((wen && !full) ? 1 : 0)
                && in_ready === 1'b1) begin
                sb.push_back(in_data);
                m_cnt++;
            end
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d,
                         input logic f);
        @(posedge wclk);
        #1;
        in_valid = v;
        in_data  = d;
        full     = f;
    endtask

    task automatic test_reset();
        wrst = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h5A;
        rptr_gray = 6'b000011;
        waddr = 6'd9;
        repeat (3) @(posedge wclk);
        #2;
        checks++;
        if (in_ready !== 1'b1 || wen !== 1'b0 || wdata !== '0) begin
            errors++;
            $display("FAIL reset_hs: got rdy=%b wen=%b wd=%h want 1 0 00",
                     in_ready, wen, wdata);
        end
        checks++;
        if (rptr_sync !== '0 || level !== '0 || almost_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_ptr: got sync=%h lvl=%0d af=%b want 0 0 0",
                     rptr_sync, level, almost_full);
        end
        checks++;
        if (wr_count !== 16'd0 || level_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt: got wc=%0d err=%b want 0 0",
                     wr_count, level_err);
        end
        in_valid = 1'b0;
        rptr_gray = '0;
        waddr = '0;
        sb.delete();
        m_cnt = 0;
        wrst = 1'b1;
    endtask

    task automatic test_basic();
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        checks++;
        if (wen !== 1'b1 || wdata !== 8'h11) begin
            errors++;
            $display("FAIL basic_first: got wen=%b wd=%h want 1 11", wen, wdata);
        end
        drive(1'b1, 8'h33, 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (wr_count !== 16'd3 || sb.size() != 0) begin
            errors++;
            $display("FAIL basic_count: got wc=%0d q=%0d want 3 0",
                     wr_count, sb.size());
        end
    endtask

    task automatic test_full_hold();
        drive(1'b1, 8'hA1, 1'b1);
        drive(1'b1, 8'hA2, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (in_ready !== 1'b0 || wen !== 1'b1 || wdata !== 8'hA1) begin
            errors++;
            $display("FAIL full_hold: got rdy=%b wen=%b wd=%h want 0 1 a1",
                     in_ready, wen, wdata);
        end
        drive(1'b1, 8'hEE, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (wdata !== 8'hA1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_stable: got wd=%h rdy=%b want a1 0",
                     wdata, in_ready);
        end
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (wr_count !== 16'd5 || wen !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: got wc=%0d wen=%b want 5 0",
                     wr_count, wen);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 8'h40, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b0);
            checks++;
            if (wen !== 1'b1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_cnt1: got wen=%b rdy=%b want 1 1",
                         wen, in_ready);
            end
        end
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (wr_count !== 16'd16 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got wc=%0d q=%0d want 16 0",
                     wr_count, sb.size());
        end
    endtask

    task automatic test_sync_level();
        waddr = 6'd3;
        rptr_gray = 6'b000000;
        repeat (4) @(posedge wclk);
        #1;
        checks++;
        if (level !== 6'd3) begin
            errors++;
            $display("FAIL lvl_base: got %0d want 3", level);
        end
        rptr_gray = 6'b100000;
        repeat (2) @(posedge wclk);
        #1;
        checks++;
        if (rptr_sync !== 6'b100000 || level !== 6'd3) begin
            errors++;
            $display("FAIL lvl_sync2: got sync=%b lvl=%0d want 100000 3",
                     rptr_sync, level);
        end
        @(posedge wclk);
        #1;
        checks++;
        if (level !== 6'd4 || level_err !== 1'b0) begin
            errors++;
            $display("FAIL lvl_wrap: got lvl=%0d err=%b want 4 0",
                     level, level_err);
        end
    endtask

    task automatic test_almost_full();
        rptr_gray = 6'b000000;
        waddr = 6'd28;
        repeat (5) @(posedge wclk);
        #1;
        checks++;
        if (level !== 6'd28 || almost_full !== 1'b1) begin
            errors++;
            $display("FAIL af_28: got lvl=%0d af=%b want 28 1",
                     level, almost_full);
        end
        waddr = 6'd27;
        @(posedge wclk);
        #1;
        checks++;
        if (level !== 6'd27 || almost_full !== 1'b1) begin
            errors++;
            $display("FAIL af_lag: got lvl=%0d af=%b want 27 1",
                     level, almost_full);
        end
        @(posedge wclk);
        #1;
        checks++;
        if (almost_full !== 1'b0 || level_err !== 1'b0) begin
            errors++;
            $display("FAIL af_27: got af=%b err=%b want 0 0",
                     almost_full, level_err);
        end
        waddr = 6'd40;
        @(posedge wclk);
        #1;
        checks++;
        if (level_err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got %b want 1", level_err);
        end
        waddr = 6'd0;
        repeat (3) @(posedge wclk);
        #1;
        checks++;
        if (level_err !== 1'b1 || level !== 6'd0) begin
            errors++;
            $display("FAIL err_sticky: got err=%b lvl=%0d want 1 0",
                     level_err, level);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'hB1, 1'b1);
        drive(1'b1, 8'hB2, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (in_ready !== 1'b0 || wen !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: got rdy=%b wen=%b want 0 1", in_ready, wen);
        end
        #1;
        wrst = 1'b0;
        sb.delete();
        m_cnt = 0;
        #1;
        checks++;
        if (wen !== 1'b0 || in_ready !== 1'b1 || wdata !== '0) begin
            errors++;
            $display("FAIL arst_now: got wen=%b rdy=%b wd=%h want 0 1 00",
                     wen, in_ready, wdata);
        end
        checks++;
        if (wr_count !== 16'd0 || level_err !== 1'b0) begin
            errors++;
            $display("FAIL arst_cnt: got wc=%0d err=%b want 0 0",
                     wr_count, level_err);
        end
        full = 1'b0;
        @(posedge wclk);
        #1;
        wrst = 1'b1;
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (wen !== 1'b0 || wr_count !== 16'd0) begin
            errors++;
            $display("FAIL arst_stale: got wen=%b wc=%0d want 0 0",
                     wen, wr_count);
        end
        drive(1'b1, 8'hC7, 1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (wr_count !== 16'd1 || sb.size() != 0) begin
            errors++;
            $display("FAIL arst_after: got wc=%0d q=%0d want 1 0",
                     wr_count, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_hold();
        test_back_to_back();
        test_sync_level();
        test_almost_full();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
